// File: rtl/paquete_leds_pkg.sv
// Shared types and default constants for the SECDED LED display stage.
package paquete_leds_pkg;

   typedef enum logic [1:0] {
      REPOSO      = 2'd0,
      MOSTRAR     = 2'd1,
      ERROR_DOBLE = 2'd2
   } estado_leds_t;

   localparam int CICLOS_PARPADEO_DEF = 13_500_000;
   localparam int ANCHO_CUENTA_DEF    = 8;

endpackage

// File: rtl/temporizador_parpadeo.sv
// Blink phase generator: counts 0..CICLOS-1 and toggles the phase on each wrap.
module temporizador_parpadeo #(
   parameter int CICLOS = paquete_leds_pkg::CICLOS_PARPADEO_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic reiniciar,
   input  logic habilitar,
   output logic fase
);

   localparam int              ANCHO  = $clog2(CICLOS);
   localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(CICLOS - 1);

   logic [ANCHO-1:0] cuenta_q, cuenta_d;
   logic             fase_q, fase_d;

   always_comb begin
      cuenta_d = cuenta_q;
      fase_d   = fase_q;
      // A restart always lands in the "on" half, regardless of enable.
      if (reiniciar) begin
         cuenta_d = '0;
         fase_d   = 1'b1;
      end else if (habilitar) begin
         if (cuenta_q == ULTIMO) begin
            cuenta_d = '0;
            fase_d   = ~fase_q;
         end else begin
            cuenta_d = cuenta_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cuenta_q <= '0;
         fase_q   <= 1'b1;
      end else begin
         cuenta_q <= cuenta_d;
         fase_q   <= fase_d;
      end
   end

   assign fase = fase_q;

endmodule

// File: rtl/despliegue_leds_secded.sv
// LED display stage after the SECDED decoder: shows corrected words, blinks on
// double errors and keeps saturating single/double error counts.
//
// state       | meaning
// REPOSO      | nothing received yet, logical LEDs off
// MOSTRAR     | latched word on leds, latched single-error flag on led_correccion
// ERROR_DOBLE | uncorrectable word seen, all data LEDs blink
module despliegue_leds_secded
   import paquete_leds_pkg::*;
#(
   parameter int ANCHO_DATOS     = 4,
   parameter int ACTIVO_BAJO     = 1,
   parameter int CICLOS_PARPADEO = CICLOS_PARPADEO_DEF,
   parameter int ANCHO_CUENTA    = ANCHO_CUENTA_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valido,
   input  logic [ANCHO_DATOS-1:0]  w_corregida,
   input  logic                    error_simple,
   input  logic                    error_doble,
   input  logic                    borrar_cuentas,
   output logic [ANCHO_DATOS-1:0]  leds,
   output logic                    led_correccion,
   output logic [ANCHO_CUENTA-1:0] cuenta_simples,
   output logic [ANCHO_CUENTA-1:0] cuenta_dobles
);

   localparam logic POL = (ACTIVO_BAJO != 0);

   estado_leds_t            estado_q, estado_d;
   logic [ANCHO_DATOS-1:0]  dato_q, dato_d;
   logic                    simple_q, simple_d;
   logic [ANCHO_CUENTA-1:0] cnt_s_q, cnt_s_d;
   logic [ANCHO_CUENTA-1:0] cnt_d_q, cnt_d_d;

   logic [ANCHO_DATOS-1:0]  leds_q, leds_d;
   logic                    corr_q, corr_d;
   logic [ANCHO_CUENTA-1:0] cs_out_q, cs_out_d;
   logic [ANCHO_CUENTA-1:0] cd_out_q, cd_out_d;

   logic                    reiniciar;
   logic                    fase;

   assign reiniciar = valido & error_doble;

   temporizador_parpadeo #(
      .CICLOS (CICLOS_PARPADEO)
   ) u_temporizador (
      .clk       (clk),
      .rst       (rst),
      .reiniciar (reiniciar),
      .habilitar (estado_q == ERROR_DOBLE),
      .fase      (fase)
   );

   always_comb begin
      estado_d = estado_q;
      dato_d   = dato_q;
      simple_d = simple_q;
      if (valido) begin
         if (error_doble) begin
            estado_d = ERROR_DOBLE;
            simple_d = 1'b0;
         end else begin
            estado_d = MOSTRAR;
            dato_d   = w_corregida;
            simple_d = error_simple;
         end
      end
   end

   always_comb begin
      cnt_s_d = cnt_s_q;
      cnt_d_d = cnt_d_q;
      if (borrar_cuentas) begin
         cnt_s_d = '0;
         cnt_d_d = '0;
      end else if (valido) begin
         // Double error takes precedence when both flags are raised.
         if (error_doble) begin
            if (cnt_d_q != '1) cnt_d_d = cnt_d_q + 1'b1;
         end else if (error_simple) begin
            if (cnt_s_q != '1) cnt_s_d = cnt_s_q + 1'b1;
         end
      end
   end

   // Logical values are decided here; polarity is applied only on the way out.
   always_comb begin
      leds_d   = '0;
      corr_d   = 1'b0;
      cs_out_d = cnt_s_q;
      cd_out_d = cnt_d_q;
      unique case (estado_q)
         MOSTRAR: begin
            leds_d = dato_q;
            corr_d = simple_q;
         end
         ERROR_DOBLE: begin
            leds_d = {ANCHO_DATOS{fase}};
         end
         default: begin
            leds_d = '0;
         end
      endcase
      leds_d = leds_d ^ {ANCHO_DATOS{POL}};
      corr_d = corr_d ^ POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= REPOSO;
         dato_q   <= '0;
         simple_q <= 1'b0;
         cnt_s_q  <= '0;
         cnt_d_q  <= '0;
         leds_q   <= {ANCHO_DATOS{POL}};
         corr_q   <= POL;
         cs_out_q <= '0;
         cd_out_q <= '0;
      end else begin
         estado_q <= estado_d;
         dato_q   <= dato_d;
         simple_q <= simple_d;
         cnt_s_q  <= cnt_s_d;
         cnt_d_q  <= cnt_d_d;
         leds_q   <= leds_d;
         corr_q   <= corr_d;
         cs_out_q <= cs_out_d;
         cd_out_q <= cd_out_d;
      end
   end

   assign leds           = leds_q;
   assign led_correccion = corr_q;
   assign cuenta_simples = cs_out_q;
   assign cuenta_dobles  = cd_out_q;

endmodule

// File: tb/tb_despliegue_leds_secded.sv
// Directed scoreboard bench for despliegue_leds_secded (active-low LEDs, 4-cycle blink).
module tb_despliegue_leds_secded;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       valido = 1'b0;
   logic [3:0] w_corregida = '0;
   logic       error_simple = 1'b0;
   logic       error_doble = 1'b0;
   logic       borrar_cuentas = 1'b0;
   logic [3:0] leds;
   logic       led_correccion;
   logic [2:0] cuenta_simples;
   logic [2:0] cuenta_dobles;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string      tag;
      logic [3:0] leds;
      logic       corr;
      logic [2:0] cs;
      logic [2:0] cd;
   } esperado_t;

   esperado_t sb[$];

   despliegue_leds_secded #(
      .ANCHO_DATOS     (4),
      .ACTIVO_BAJO     (1),
      .CICLOS_PARPADEO (4),
      .ANCHO_CUENTA    (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valido         (valido),
      .w_corregida    (w_corregida),
      .error_simple   (error_simple),
      .error_doble    (error_doble),
      .borrar_cuentas (borrar_cuentas),
      .leds           (leds),
      .led_correccion (led_correccion),
      .cuenta_simples (cuenta_simples),
      .cuenta_dobles  (cuenta_dobles)
   );

   always #5 clk = ~clk;

   task automatic empujar(input string tag, input logic [3:0] l, input logic c,
                          input logic [2:0] s, input logic [2:0] d);
      esperado_t e;
      e.tag = tag; e.leds = l; e.corr = c; e.cs = s; e.cd = d;
      sb.push_back(e);
   endtask

   // Pops the oldest expectation and compares it with what the DUT shows now.
   task automatic comparar();
      esperado_t e;
      tests_run++;
      assert (sb.size() != 0) else begin
         tests_failed++;
         $error("FAIL scoreboard_empty: got size %0d want >0", sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         tests_run++;
         assert (leds === e.leds) else begin
            tests_failed++;
            $error("FAIL %s leds: got %b want %b", e.tag, leds, e.leds);
         end
         tests_run++;
         assert (led_correccion === e.corr) else begin
            tests_failed++;
            $error("FAIL %s led_correccion: got %b want %b", e.tag, led_correccion, e.corr);
         end
         tests_run++;
         assert (cuenta_simples === e.cs) else begin
            tests_failed++;
            $error("FAIL %s cuenta_simples: got %0d want %0d", e.tag, cuenta_simples, e.cs);
         end
         tests_run++;
         assert (cuenta_dobles === e.cd) else begin
            tests_failed++;
            $error("FAIL %s cuenta_dobles: got %0d want %0d", e.tag, cuenta_dobles, e.cd);
         end
      end
   endtask

   // One-cycle valido pulse; returns at the falling edge right after the sampling edge.
   task automatic pulso(input logic [3:0] w, input logic es, input logic ed, input logic br);
      @(negedge clk);
      valido = 1'b1; w_corregida = w; error_simple = es; error_doble = ed; borrar_cuentas = br;
      @(negedge clk);
      valido = 1'b0; error_simple = 1'b0; error_doble = 1'b0; borrar_cuentas = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      empujar("reset", 4'b1111, 1'b1, 3'd0, 3'd0);
      comparar();

      pulso(4'b1010, 1'b0, 1'b0, 1'b0);
      empujar("clean", 4'b0101, 1'b1, 3'd0, 3'd0);
      @(negedge clk); comparar();

      pulso(4'b0011, 1'b1, 1'b0, 1'b0);
      empujar("single", 4'b1100, 1'b0, 3'd1, 3'd0);
      @(negedge clk); comparar();

      // Inputs without valido must be ignored.
      @(negedge clk);
      w_corregida = 4'b1111; error_doble = 1'b1; error_simple = 1'b1;
      @(negedge clk);
      error_doble = 1'b0; error_simple = 1'b0;
      empujar("gating", 4'b1100, 1'b0, 3'd1, 3'd0);
      @(negedge clk); comparar();

      pulso(4'b0110, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         empujar("blink", (i < 4 || i >= 8) ? 4'b0000 : 4'b1111, 1'b1, 3'd1, 3'd1);
         @(negedge clk); comparar();
      end

      pulso(4'b0001, 1'b0, 1'b0, 1'b0);
      empujar("exit_blink", 4'b1110, 1'b1, 3'd1, 3'd1);
      @(negedge clk); comparar();

      for (int i = 0; i < 9; i++) pulso(4'b0110, 1'b1, 1'b0, 1'b0);
      empujar("saturate", 4'b1001, 1'b0, 3'd7, 3'd1);
      @(negedge clk); comparar();

      pulso(4'b1000, 1'b1, 1'b0, 1'b1);
      empujar("clear_with_valid", 4'b0111, 1'b0, 3'd0, 3'd0);
      @(negedge clk); comparar();

      pulso(4'b0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         empujar("blink2", (i < 4) ? 4'b0000 : 4'b1111, 1'b1, 3'd0, 3'd1);
         @(negedge clk); comparar();
      end
      rst = 1'b1;
      empujar("rst_mid_blink", 4'b1111, 1'b1, 3'd0, 3'd0);
      @(negedge clk); comparar();
      rst = 1'b0;
      // Blinking would have returned to the "on" half here; REPOSO keeps LEDs dark.
      for (int i = 0; i < 6; i++) begin
         empujar("reposo_after_rst", 4'b1111, 1'b1, 3'd0, 3'd0);
         @(negedge clk); comparar();
      end

      pulso(4'b0101, 1'b0, 1'b0, 1'b0);
      empujar("clean_after_rst", 4'b1010, 1'b1, 3'd0, 3'd0);
      @(negedge clk); comparar();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
